fifo_word_packer: RTL



---
 rtl/fifo_pkg.sv | 15 +
 rtl/word_out_reg.sv | 47 ++++
 rtl/fifo_word_packer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and flush state type for the FIFO word packer
package fifo_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_KEEP_WIDTH     = DEF_BYTES_PER_WORD;
    localparam int DEF_WORD_WIDTH     = DEF_DATA_WIDTH * DEF_BYTES_PER_WORD;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_DRAIN = 2'd1,
        FLUSH_EMIT  = 2'd2
    } flush_state_t;

endpackage

// File: rtl/word_out_reg.sv
// rtl/word_out_reg.sv - single-entry valid/ready output register for packed words
module word_out_reg
    import fifo_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_WIDTH,
    parameter int KEEP_W = DEF_KEEP_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_slot_free
);

    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              w_slot_free;

    // The slot is reusable in the same cycle the current word is accepted.
    assign w_slot_free = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (i_load && w_slot_free) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_keep      = r_keep;
    assign o_slot_free = w_slot_free;

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - pops bytes from the sync FIFO and packs them into keep-masked words
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 fifo_empty,
    output logic                                 fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]                fifo_dout,
    input  logic                                 flush,
    output logic                                 flush_done,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]            out_keep
);

    localparam int WORD_W = DATA_WIDTH * BYTES_PER_WORD;
    localparam int KEEP_W = BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

    flush_state_t r_state;
    flush_state_t w_state_next;

    logic [CNT_W-1:0]                           r_acc_cnt;
    logic [CNT_W-1:0]                           w_acc_cnt_next;
    logic [CNT_W-1:0]                           w_occupancy;
    logic                                       r_inflight;
    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] r_acc;
    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] w_acc_next;
    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] w_partial;
    logic [KEEP_W-1:0]                          w_partial_keep;

    logic              w_slot_free;
    logic              w_pop;
    logic              w_load;
    logic [WORD_W-1:0] w_load_data;
    logic [KEEP_W-1:0] w_load_keep;
    logic              w_flush_done_next;
    logic              r_flush_done;

    // Second term lets the next byte issue while the last lane lands, so word boundaries cost no bubble.
    assign w_occupancy = r_acc_cnt + CNT_W'(r_inflight);
    assign w_pop = rst_n && !fifo_empty && (r_state == FLUSH_IDLE) &&
                   ((w_occupancy < CNT_FULL) ||
                    (r_inflight && (r_acc_cnt == CNT_LAST) && w_slot_free));

    assign fifo_rd_en = w_pop;
    assign flush_done = r_flush_done;

    always_comb begin
        w_partial      = '0;
        w_partial_keep = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            w_partial_keep[i] = (CNT_W'(i) < r_acc_cnt);
            w_partial[i]      = w_partial_keep[i] ? r_acc[i] : '0;
        end
    end

    always_comb begin
        w_acc_next        = r_acc;
        w_acc_cnt_next    = r_acc_cnt;
        w_load            = 1'b0;
        w_load_data       = r_acc;
        w_load_keep       = '1;
        w_state_next      = r_state;
        w_flush_done_next = 1'b0;

        if (r_acc_cnt == CNT_FULL) begin
            if (w_slot_free) begin
                w_load         = 1'b1;
                w_acc_cnt_next = '0;
            end
        end else if (r_inflight) begin
            w_acc_next[r_acc_cnt[LANE_W-1:0]] = fifo_dout;
            if (r_acc_cnt == CNT_LAST) begin
                if (w_slot_free) begin
                    w_load         = 1'b1;
                    w_load_data    = w_acc_next;
                    w_acc_cnt_next = '0;
                end else begin
                    w_acc_cnt_next = CNT_FULL;
                end
            end else begin
                w_acc_cnt_next = r_acc_cnt + CNT_W'(1);
            end
        end

        case (r_state)
            FLUSH_IDLE: begin
                if (flush) begin
                    w_state_next = FLUSH_DRAIN;
                end
            end
            FLUSH_DRAIN: begin
                // A held full word is emitted by the normal path before the flush decides.
                if (!r_inflight && (r_acc_cnt != CNT_FULL)) begin
                    if (r_acc_cnt != '0) begin
                        w_state_next = FLUSH_EMIT;
                    end else begin
                        w_flush_done_next = 1'b1;
                        w_state_next      = FLUSH_IDLE;
                    end
                end
            end
            FLUSH_EMIT: begin
                if (w_slot_free) begin
                    w_load            = 1'b1;
                    w_load_data       = w_partial;
                    w_load_keep       = w_partial_keep;
                    w_acc_cnt_next    = '0;
                    w_flush_done_next = 1'b1;
                    w_state_next      = FLUSH_IDLE;
                end
            end
            default: begin
                w_state_next = FLUSH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FLUSH_IDLE;
            r_acc_cnt    <= '0;
            r_inflight   <= 1'b0;
            r_acc        <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_acc_cnt    <= w_acc_cnt_next;
            r_inflight   <= w_pop;
            r_acc        <= w_acc_next;
            r_flush_done <= w_flush_done_next;
        end
    end

    word_out_reg #(
        .WORD_W (WORD_W),
        .KEEP_W (KEEP_W)
    ) u_word_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_data      (w_load_data),
        .i_keep      (w_load_keep),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_keep      (out_keep),
        .o_slot_free (w_slot_free)
    );

endmodule
